mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port ssram between the rv32i instruction fetch port and data load/store port (unified code+data memory).
//  Sits between riscv_rv32i and a single ssram instance; replaces the split code/data ssram pair when one memory is used.
//  Serialises accesses through a 3-state FSM with fixed data priority and a starvation guard for fetch.
// PARAMETERS
//  ADDR_W          32  byte-address width of both requester ports
//  DATA_W          32  data width; byte enables are DATA_W/8 wide
//  MAX_DATA_BURST  4   consecutive data grants allowed while i_req waits; next grant goes to fetch (>=1)
// PORTS
//  clk        in   1           clock; all logic on rising edge
//  rst        in   1           reset, synchronous, active-low
//  i_req      in   1           fetch request; level, held until i_ack
//  i_addr     in   ADDR_W      fetch byte address; bits [1:0] ignored
//  i_ack      out  1           one-cycle fetch completion pulse
//  i_rdata    out  DATA_W      fetch data, valid only while i_ack
//  d_rd_req   in   1           data read request; level, held until d_rd_ack
//  d_wr_req   in   1           data write request; level, held until d_wr_ack
//  d_addr     in   ADDR_W      data byte address; bits [1:0] ignored
//  d_wdata    in   DATA_W      write data
//  d_be       in   DATA_W/8    write byte enables
//  d_rd_ack   out  1           one-cycle read completion pulse
//  d_rdata    out  DATA_W      read data, valid only while d_rd_ack
//  d_wr_ack   out  1           one-cycle write completion pulse
//  m_addr     out  ADDR_W-2    ssram word address (byte address >> 2)
//  m_re       out  1           ssram read enable
//  m_we       out  1           ssram write enable
//  m_be       out  DATA_W/8    ssram write byte enables
//  m_wdata    out  DATA_W      ssram write data
//  m_rdata    in   DATA_W      ssram read data, valid cycle after m_re
//  busy       out  1           high whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE; m_re/m_we/acks 0; m_addr/m_be/m_wdata 0; starve_cnt 0; grant owner cleared.
//  - Reset mid-access aborts it silently; no ack issued; held requests re-serviced from IDLE after rst returns high.
//  - All m_* outputs and acks are registered. i_rdata = i_ack ? m_rdata : 0; d_rdata = d_rd_ack ? m_rdata : 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles max.
//  - IDLE: if any request, pick winner, register m_addr/m_re or m_we/m_be/m_wdata, record owner, go ACCESS; else stay.
//  - ACCESS: exactly one cycle with m_re or m_we high (never both); go RESP.
//  - RESP: owner's ack high for exactly this cycle; m_re/m_we low; go IDLE unconditionally (no re-arbitration in RESP,
//    so a still-high req from the acked requester is not double-serviced).
//  - Latency: request sampled at edge E0 in IDLE -> strobe in cycle after E0 -> ack in following cycle (ack at E0+2).
//  - Priority in IDLE: d_wr_req > d_rd_req > i_req, except i_req wins when starve_cnt == MAX_DATA_BURST.
//  - starve_cnt: +1 on each data grant made while i_req high (saturates at MAX_DATA_BURST); cleared on fetch grant
//    or on any grant made while i_req low.
//  - d_rd_req and d_wr_req both high: write served first, read stays pending and is served on a later grant.
//  - Requests/address/data must be stable from assertion until ack; changes before ack are undefined.
//  - Read data is not buffered; requester samples it in the ack cycle.
// TESTING
//  1 Fetch: i_req=1, i_addr=0x10, mem[4]=0x00500093 -> m_re one cycle, m_addr=4; i_ack pulse 2 cycles later, i_rdata=0x00500093.
//  2 Write: d_wr_req, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=4'b0011 -> m_we one cycle, m_addr=8, m_be=0011; d_wr_ack pulse;
//    then read 0x20 over a memory holding 0 -> d_rdata=0x0000BEEF.
//  3 Starvation: i_req and d_rd_req held, MAX_DATA_BURST=4 -> grants D,D,D,D,I,D...; i_ack on 5th access; starve_cnt returns to 0.
//  4 d_rd_req+d_wr_req together -> write access then read access; exactly one d_wr_ack then one d_rd_ack, never same cycle.
//  5 rst=0 during ACCESS -> next cycle m_re=m_we=0, acks 0, busy=0; after rst=1 the held i_req completes with correct data.
//  6 Idle: all reqs 0 for 20 cycles -> m_re=m_we=0, busy=0, all acks 0, rdata outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the rv32i instruction fetch port and the data load/store port share
//   one single-port ssram (unified code + data memory). Each access takes
//   three cycles: IDLE -> ACCESS -> RESP. Data always has priority, but fetch
//   is forced through after MAX_DATA_BURST back-to-back data grants so it
//   cannot be starved.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | arbitrate; register the winner's strobe, address and data
//   ACCESS | ssram strobe (m_re or m_we) is high for this one cycle
//   RESP   | owner's ack high, ssram read data valid; always back to IDLE
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   i_req/i_addr                fetch request (level) and byte address
//   i_ack/i_rdata               fetch completion pulse and read data
//   d_rd_req/d_wr_req           data read / write requests (level)
//   d_addr/d_wdata/d_be         data byte address, write data, byte enables
//   d_rd_ack/d_rdata/d_wr_ack   data completion pulses and read data
//   m_addr/m_re/m_we/m_be/m_wdata/m_rdata  ssram word-addressed port
//   busy                        high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_rd_req,
  input  logic                d_wr_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rd_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wr_ack,
  output logic [ADDR_W-3:0]   m_addr,
  output logic                m_re,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DRD   = 2'd2;
  localparam logic [1:0] OWN_DWR   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-3:0] m_addr_q, m_addr_d;
  logic              m_re_q, m_re_d;
  logic              m_we_q, m_we_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_rd_ack_q, d_rd_ack_d;
  logic              d_wr_ack_q, d_wr_ack_d;
  logic              fetch_wins;

  // Word addressing drops the byte-offset bits.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // Fetch wins when data has used up its burst allowance or nothing else asks.
  assign fetch_wins = i_req && ((starve_cnt_q == CNT_MAX) || !(d_wr_req || d_rd_req));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    m_addr_d     = m_addr_q;
    m_be_d       = m_be_q;
    m_wdata_d    = m_wdata_q;
    m_re_d       = 1'b0;
    m_we_d       = 1'b0;
    i_ack_d      = 1'b0;
    d_rd_ack_d   = 1'b0;
    d_wr_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_rd_req || d_wr_req) begin
          state_d = ST_ACCESS;
          if (fetch_wins) begin
            owner_d      = OWN_FETCH;
            m_addr_d     = i_addr[ADDR_W-1:2];
            m_re_d       = 1'b1;
            m_be_d       = '0;
            m_wdata_d    = '0;
            starve_cnt_d = '0;
          end else begin
            m_addr_d = d_addr[ADDR_W-1:2];
            if (d_wr_req) begin
              owner_d   = OWN_DWR;
              m_we_d    = 1'b1;
              m_be_d    = d_be;
              m_wdata_d = d_wdata;
            end else begin
              owner_d   = OWN_DRD;
              m_re_d    = 1'b1;
              m_be_d    = '0;
              m_wdata_d = '0;
            end
            // Only data grants that make a waiting fetch wait longer count.
            if (!i_req)
              starve_cnt_d = '0;
            else if (starve_cnt_q != CNT_MAX)
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        i_ack_d    = (owner_q == OWN_FETCH);
        d_rd_ack_d = (owner_q == OWN_DRD);
        d_wr_ack_d = (owner_q == OWN_DWR);
      end
      ST_RESP: begin
        // No arbitration here: the acked requester still holds its req.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      m_addr_q     <= '0;
      m_re_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_be_q       <= '0;
      m_wdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_rd_ack_q   <= 1'b0;
      d_wr_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      m_addr_q     <= m_addr_d;
      m_re_q       <= m_re_d;
      m_we_q       <= m_we_d;
      m_be_q       <= m_be_d;
      m_wdata_q    <= m_wdata_d;
      i_ack_q      <= i_ack_d;
      d_rd_ack_q   <= d_rd_ack_d;
      d_wr_ack_q   <= d_wr_ack_d;
    end
  end

  assign m_addr   = m_addr_q;
  assign m_re     = m_re_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_wdata  = m_wdata_q;
  assign i_ack    = i_ack_q;
  assign d_rd_ack = d_rd_ack_q;
  assign d_wr_ack = d_wr_ack_q;
  // ssram data is only meaningful in the ack cycle; mask it otherwise.
  assign i_rdata  = i_ack_q    ? m_rdata : '0;
  assign d_rdata  = d_rd_ack_q ? m_rdata : '0;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [1:0] K_FETCH = 2'd1;
  localparam logic [1:0] K_RD    = 2'd2;
  localparam logic [1:0] K_WR    = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_rd_ack;
  logic [31:0] d_rdata;
  logic        d_wr_ack;
  logic [29:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_rd_ack(d_rd_ack),
    .d_rdata(d_rdata), .d_wr_ack(d_wr_ack),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_be(m_be),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  // ssram: registered read, byte-masked write
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (m_re) m_rdata <= mem[m_addr[7:0]];
    if (m_we)
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } resp_t;

  strobe_t strobe_q[$];
  resp_t   resp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic void push_strobe(input logic we, input logic [29:0] addr,
                                      input logic [3:0] be, input logic [31:0] wd);
    strobe_t s;
    s.we = we; s.addr = addr; s.be = be; s.wdata = wd;
    strobe_q.push_back(s);
  endfunction

  function automatic void push_resp(input logic [1:0] kind, input logic [31:0] data);
    resp_t r;
    r.kind = kind; r.data = data;
    resp_q.push_back(r);
  endfunction

  // monitor: pops expectations whenever the DUT strobes memory or acks
  always @(negedge clk) begin
    strobe_t s;
    resp_t   r;
    logic [1:0] k;
    if (m_re || m_we) begin
      check("re_we_exclusive", 64'(m_re & m_we), '0);
      if (strobe_q.size() == 0)
        fail_now("unexpected_strobe", $sformatf("got we=%0b addr=0x%0h, expected none", m_we, m_addr));
      else begin
        s = strobe_q.pop_front();
        check("strobe_we", 64'(m_we), 64'(s.we));
        check("strobe_addr", 64'(m_addr), 64'(s.addr));
        if (s.we) begin
          check("strobe_be", 64'(m_be), 64'(s.be));
          check("strobe_wdata", 64'(m_wdata), 64'(s.wdata));
        end
      end
    end
    if (i_ack || d_rd_ack || d_wr_ack) begin
      check("ack_onehot", 64'($countones({i_ack, d_rd_ack, d_wr_ack})), 64'd1);
      k = i_ack ? K_FETCH : (d_rd_ack ? K_RD : K_WR);
      if (resp_q.size() == 0)
        fail_now("unexpected_ack", $sformatf("got ack kind %0d, expected none", k));
      else begin
        r = resp_q.pop_front();
        check("ack_kind", 64'(k), 64'(r.kind));
        if (k == K_FETCH) check("i_rdata", 64'(i_rdata), 64'(r.data));
        if (k == K_RD)    check("d_rdata", 64'(d_rdata), 64'(r.data));
      end
    end
  end

  // which: 1 fetch, 2 data read, 3 data write; cycles = negedges until ack seen
  task automatic wait_ack(input int which, output int cycles);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if ((which == 1 && i_ack) || (which == 2 && d_rd_ack) || (which == 3 && d_wr_ack)) begin
        cycles = c;
        return;
      end
    end
    fail_now("ack_timeout", $sformatf("no ack of kind %0d within 30 cycles", which));
    cycles = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rd_n;
    bit done;
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4]  = 32'h0050_0093;
    mem[5]  = 32'h1111_1111;
    mem[12] = 32'hCAFE_F00D;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({m_re, m_we, busy, i_ack, d_rd_ack, d_wr_ack}), '0);
    check("reset_m_addr", 64'(m_addr), '0);
    check("reset_m_be_wdata", 64'({m_be, m_wdata}), '0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single fetch
    push_strobe(1'b0, 30'd4, 4'h0, 32'h0);
    push_resp(K_FETCH, 32'h0050_0093);
    i_req = 1'b1; i_addr = 32'h10;
    wait_ack(1, cyc);
    i_req = 1'b0;
    check("fetch_latency", 64'(cyc), 64'd2);
    @(negedge clk);

    // 2: partial write then read back
    push_strobe(1'b1, 30'd8, 4'b0011, 32'hDEAD_BEEF);
    push_resp(K_WR, 32'h0);
    d_wr_req = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    wait_ack(3, cyc);
    d_wr_req = 1'b0;
    check("write_latency", 64'(cyc), 64'd2);
    @(negedge clk);
    push_strobe(1'b0, 30'd8, 4'h0, 32'h0);
    push_resp(K_RD, 32'h0000_BEEF);
    d_rd_req = 1'b1;
    wait_ack(2, cyc);
    d_rd_req = 1'b0;
    check("read_latency", 64'(cyc), 64'd2);
    @(negedge clk);

    // 3: starvation guard, grants D,D,D,D,I,D
    for (int i = 0; i < 4; i++) begin
      push_strobe(1'b0, 30'd12, 4'h0, 32'h0);
      push_resp(K_RD, 32'hCAFE_F00D);
    end
    push_strobe(1'b0, 30'd5, 4'h0, 32'h0);
    push_resp(K_FETCH, 32'h1111_1111);
    push_strobe(1'b0, 30'd12, 4'h0, 32'h0);
    push_resp(K_RD, 32'hCAFE_F00D);
    i_req = 1'b1; i_addr = 32'h14; d_rd_req = 1'b1; d_addr = 32'h30;
    rd_n = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (i_ack) i_req = 1'b0;
      if (d_rd_ack) begin
        rd_n++;
        if (rd_n == 5) d_rd_req = 1'b0;
      end
      if (!i_req && !d_rd_req) done = 1'b1;
    end
    if (!done) begin
      fail_now("starve_timeout", "requests not all served within 60 cycles");
      i_req = 1'b0; d_rd_req = 1'b0;
    end
    check("starve_rd_count", 64'(rd_n), 64'd5);
    @(negedge clk);
    check("starve_cnt_cleared", 64'(dut.starve_cnt_q), '0);

    // 4: simultaneous read and write to one address
    push_strobe(1'b1, 30'd16, 4'hF, 32'h1234_5678);
    push_resp(K_WR, 32'h0);
    push_strobe(1'b0, 30'd16, 4'h0, 32'h0);
    push_resp(K_RD, 32'h1234_5678);
    d_addr = 32'h40; d_wdata = 32'h1234_5678; d_be = 4'hF;
    d_wr_req = 1'b1; d_rd_req = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (d_wr_ack) d_wr_req = 1'b0;
      if (d_rd_ack) d_rd_req = 1'b0;
      if (!d_wr_req && !d_rd_req) done = 1'b1;
    end
    if (!done) begin
      fail_now("rdwr_timeout", "read+write not served within 40 cycles");
      d_wr_req = 1'b0; d_rd_req = 1'b0;
    end
    @(negedge clk);

    // 5: reset during ACCESS aborts; held fetch then completes
    push_strobe(1'b0, 30'd4, 4'h0, 32'h0);
    push_strobe(1'b0, 30'd4, 4'h0, 32'h0);
    push_resp(K_FETCH, 32'h0050_0093);
    i_req = 1'b1; i_addr = 32'h10;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (m_re) done = 1'b1;
    end
    if (!done) fail_now("rst_strobe_timeout", "no fetch strobe within 10 cycles");
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_ctrl", 64'({m_re, m_we, busy, i_ack, d_rd_ack, d_wr_ack}), '0);
    rst = 1'b1;
    wait_ack(1, cyc);
    i_req = 1'b0;
    check("post_rst_latency", 64'(cyc), 64'd2);
    @(negedge clk);

    // 6: idle
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_ctrl", 64'({m_re, m_we, busy, i_ack, d_rd_ack, d_wr_ack}), '0);
      check("idle_rdata", {i_rdata, d_rdata}, '0);
    end

    check("strobe_queue_empty", 64'(strobe_q.size()), '0);
    check("resp_queue_empty", 64'(resp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
